// File: rtl/spi_master_gen_pkg.sv
// Shared types and constants for the SPI master.
// Holds the FSM state type, the {cpol,cpha} mode codes, default parameter
// values and the width and bit-position helpers used by the top level.
package spi_master_gen_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NCS    = 4;
  localparam int DEF_DIV_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // SPI mode encoding as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Width of a bit-count field able to hold 0..data_w
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Width of an index into a data_w-bit word
  function automatic int idx_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  // Width of the chip-select selector
  function automatic int cs_width(input int ncs);
    return (ncs > 1) ? $clog2(ncs) : 1;
  endfunction

  // Word position of the current bit, given how many bits remain (including
  // the current one). Used for both transmit and receive, so the received
  // word ends up right-justified in either bit order.
  function automatic int bit_pos(input int bits_left, input int n, input logic lsb);
    return lsb ? (n - bits_left) : (bits_left - 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   en         : count while high (any non-idle state)
//   start      : reload the counter with div and restart the phase at an
//                even (leading-edge) half-period; has priority over en
//   div        : half-period length minus one
//   hp_end     : strobe on the last cycle of each half-period
//   trail_ph   : 0 = current half ends with a leading edge, 1 = trailing
module spi_clk_gen
  import spi_master_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  output logic             hp_end,
  output logic             trail_ph
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Down-counter from div to 0 gives div+1 cycles without ever wrapping.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (start) begin
      cnt_d   = div;
      phase_d = 1'b0;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_d   = div;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign hp_end   = en && (cnt_q == '0);
  assign trail_ph = phase_q;

endmodule

// File: rtl/spi_master_gen.sv
// Full-duplex SPI master with runtime mode, divider, length, bit order and
// chip-select selection, and a req/ack handshake.
// Ports:
//   clk, rst_n         : system clock, async active-low reset
//   req                : transfer request, taken when busy=0
//   wr_data, nbits,
//   div, cpol, cpha,
//   lsb_first, cs_sel  : transfer configuration, latched on accept
//   busy, ack          : in-transfer flag, one-cycle completion pulse
//   rd_data            : received word, right-justified
//   sclk, mosi, miso   : SPI bus
//   cs_n               : active-low chip selects
//
// state | meaning
// IDLE  | waiting for req; sclk follows cpol input
// SETUP | chip select active, sclk idle, one half-period before first edge
// SHIFT | 2N half-periods of clock toggling, shifting and sampling
// HOLD  | one half-period with sclk idle before chip select is released
module spi_master_gen
  import spi_master_gen_pkg::*;
#(
  parameter int   DATA_W    = DEF_DATA_W,
  parameter int   NCS       = DEF_NCS,
  parameter int   DIV_W     = DEF_DIV_W,
  parameter logic MOSI_IDLE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [cnt_width(DATA_W)-1:0] nbits,
  input  logic [DIV_W-1:0]             div,
  input  logic                         cpol,
  input  logic                         cpha,
  input  logic                         lsb_first,
  input  logic [cs_width(NCS)-1:0]     cs_sel,
  output logic                         busy,
  output logic                         ack,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         sclk,
  output logic                         mosi,
  input  logic                         miso,
  output logic [NCS-1:0]               cs_n
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam int IDX_W = idx_width(DATA_W);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NCS-1:0]    cs_n_q, cs_n_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;

  logic              clk_en, clk_start, hp_end, trail_ph;
  logic              lead_edge, trail_edge, sample_lead;
  logic [DIV_W-1:0]  div_ld;
  logic [CNT_W-1:0]  n_eff;
  logic [IDX_W-1:0]  cur_idx, next_idx, first_idx;

  assign clk_en     = (state_q != IDLE);
  // In IDLE the counter can only be (re)started by an accept, which must use
  // the incoming divider rather than the previous transfer's.
  assign div_ld     = (state_q == IDLE) ? div : div_q;
  assign lead_edge  = hp_end && !trail_ph;
  assign trail_edge = hp_end && trail_ph;

  spi_clk_gen #(
    .DIV_W (DIV_W)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (clk_en),
    .start    (clk_start),
    .div      (div_ld),
    .hp_end   (hp_end),
    .trail_ph (trail_ph)
  );

  assign n_eff = ((nbits == '0) || (32'(nbits) > DATA_W)) ? CNT_W'(DATA_W) : nbits;

  assign first_idx = IDX_W'(bit_pos(int'(n_eff), int'(n_eff), lsb_first));
  assign cur_idx   = IDX_W'(bit_pos(int'(bits_left_q), int'(n_q), lsb_q));
  assign next_idx  = IDX_W'(bit_pos(int'(bits_left_q) - 1, int'(n_q), lsb_q));

  always_comb begin
    sample_lead = 1'b0;
    case ({cpol_q, cpha_q})
      MODE0, MODE2: sample_lead = 1'b1;
      MODE1, MODE3: sample_lead = 1'b0;
      default:      sample_lead = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    rd_data_d   = rd_data_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    n_d         = n_q;
    bits_left_d = bits_left_q;
    div_d       = div_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    clk_start   = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (req) begin
          state_d     = SETUP;
          busy_d      = 1'b1;
          tx_d        = wr_data;
          rx_d        = '0;
          n_d         = n_eff;
          bits_left_d = n_eff;
          div_d       = div;
          cpol_d      = cpol;
          cpha_d      = cpha;
          lsb_d       = lsb_first;
          clk_start   = 1'b1;
          cs_n_d      = '1;
          // An out-of-range selector runs the transfer with no device selected.
          if (32'(cs_sel) < NCS) cs_n_d[cs_sel] = 1'b0;
          if (!cpha) mosi_d = wr_data[first_idx];
        end
      end

      SETUP: begin
        if (hp_end) begin
          state_d   = SHIFT;
          clk_start = 1'b1;
        end
      end

      SHIFT: begin
        if (hp_end) sclk_d = ~sclk_q;
        if (lead_edge) begin
          if (sample_lead) rx_d[cur_idx] = miso;
          else             mosi_d = tx_q[cur_idx];
        end
        if (trail_edge) begin
          if (!sample_lead) rx_d[cur_idx] = miso;
          if (bits_left_q == CNT_W'(1)) begin
            state_d = HOLD;
          end else begin
            bits_left_d = bits_left_q - CNT_W'(1);
            if (sample_lead) mosi_d = tx_q[next_idx];
          end
        end
      end

      HOLD: begin
        if (hp_end) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          ack_d     = 1'b1;
          rd_data_d = rx_q;
          mosi_d    = MOSI_IDLE;
          cs_n_d    = '1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      rd_data_q   <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= MOSI_IDLE;
      cs_n_q      <= '1;
      tx_q        <= '0;
      rx_q        <= '0;
      n_q         <= '0;
      bits_left_q <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      rd_data_q   <= rd_data_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      n_q         <= n_d;
      bits_left_q <= bits_left_d;
      div_q       <= div_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
    end
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign rd_data = rd_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_gen.sv
module tb_spi_master_gen;
  import spi_master_gen_pkg::*;

  localparam int DW  = 32;
  localparam int NC  = 4;
  localparam int DVW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [5:0]    nbits = '0;
  logic [DVW-1:0] div = '0;
  logic          cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [1:0]    cs_sel = '0;
  logic          busy, ack, sclk, mosi, miso;
  logic [DW-1:0] rd_data;
  logic [NC-1:0] cs_n;

  spi_master_gen #(.DATA_W(DW), .NCS(NC), .DIV_W(DVW), .MOSI_IDLE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_data(wr_data), .nbits(nbits),
    .div(div), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cs_sel(cs_sel),
    .busy(busy), .ack(ack), .rd_data(rd_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Free-running bookkeeping (snapshotted by the stimulus, never reset)
  int cyc = 0, acks = 0, cs_bad = 0;
  logic [NC-1:0] cs_exp = '1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ack) acks <= acks + 1;
    if (busy && (cs_n !== cs_exp)) cs_bad <= cs_bad + 1;
  end

  // Slave model: shifts out sl_word in transfer order, captures mosi on the
  // sampling edge of the configured mode, counts sclk edges while busy.
  logic [31:0] sl_word = '0;
  int          n_cur = 8;
  logic        cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0, loop = 1'b1;
  logic        miso_s = 1'b0;
  logic [31:0] mosi_seen = '0;
  int          rec_n = 0, sl_idx = 0, sclk_edges = 0, lead_edges = 0;
  logic        busy_prev = 1'b0, sclk_prev = 1'b0;

  assign miso = loop ? mosi : miso_s;

  function automatic logic slave_bit(input int k);
    if (k >= n_cur) return 1'b0;
    return cur_lsb ? sl_word[k] : sl_word[n_cur-1-k];
  endfunction

  always @(sclk or busy) begin
    if (busy && !busy_prev) begin
      sl_idx = 0; rec_n = 0; mosi_seen = '0;
      if (!cur_cpha) miso_s = slave_bit(0);
    end else if (busy && (sclk !== sclk_prev)) begin
      sclk_edges++;
      if (sclk !== cur_cpol) begin
        lead_edges++;
        if (!cur_cpha) begin
          if (rec_n < 32) mosi_seen[rec_n] = mosi;
          rec_n++;
        end else miso_s = slave_bit(sl_idx);
      end else begin
        if (cur_cpha) begin
          if (rec_n < 32) mosi_seen[rec_n] = mosi;
          rec_n++;
        end
        sl_idx++;
        if (!cur_cpha) miso_s = slave_bit(sl_idx);
      end
    end
    busy_prev = busy;
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_cfg(input logic [31:0] w, input int n_in, input int d, input logic pol,
                         input logic pha, input logic lsb, input int cs,
                         input logic [31:0] sw, input logic lp);
    wr_data = w; nbits = 6'(n_in); div = 16'(d); cpol = pol; cpha = pha;
    lsb_first = lsb; cs_sel = 2'(cs);
    cur_cpol = pol; cur_cpha = pha; cur_lsb = lsb;
    n_cur = (n_in == 0 || n_in > 32) ? 32 : n_in;
    sl_word = sw; loop = lp;
    cs_exp = '1; cs_exp[cs] = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic wait_ack(input int budget, output int at_cyc, output bit ok);
    ok = 1'b0; at_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin ok = 1'b1; at_cyc = cyc; break; end
    end
  endtask

  task automatic do_xfer(input string tag, input logic [31:0] w, input int n_in, input int d,
                         input logic pol, input logic pha, input logic lsb, input int cs,
                         input logic [31:0] sw, input logic lp);
    int n, acc_c, ack_c, e0, l0, c0;
    bit ok;
    logic [31:0] mask, exp_rd, exp_mo;
    n = (n_in == 0 || n_in > 32) ? 32 : n_in;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    exp_rd = (lp ? w : sw) & mask;
    exp_mo = '0;
    for (int k = 0; k < n; k++) exp_mo[k] = lsb ? w[k] : w[n-1-k];
    set_cfg(w, n_in, d, pol, pha, lsb, cs, sw, lp);
    e0 = sclk_edges; l0 = lead_edges; c0 = cs_bad;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    acc_c = cyc;
    check({tag, ":busy_on"}, 64'(busy), 64'(1));
    check({tag, ":sclk_setup"}, 64'(sclk), 64'(pol));
    wait_ack((d + 1) * (2 * n + 2) + 20, ack_c, ok);
    if (!ok) begin
      check({tag, ":ack_timeout"}, 64'(0), 64'(1));
    end else begin
      check({tag, ":latency"}, 64'(ack_c - acc_c), 64'((d + 1) * (2 * n + 2)));
      check({tag, ":rd_data"}, 64'(rd_data), 64'(exp_rd));
      check({tag, ":mosi_seq"}, 64'(mosi_seen), 64'(exp_mo));
      check({tag, ":mosi_cnt"}, 64'(rec_n), 64'(n));
      check({tag, ":sclk_edges"}, 64'(sclk_edges - e0), 64'(2 * n));
      check({tag, ":lead_edges"}, 64'(lead_edges - l0), 64'(n));
      check({tag, ":end_state"}, 64'({busy, cs_n, sclk, mosi}), 64'({1'b0, 4'hF, pol, 1'b0}));
      check({tag, ":cs_hold"}, 64'(cs_bad - c0), 64'(0));
    end
  endtask

  initial begin
    int a1, a2, acc1, acc2, snap_acks, snap_edges, r_d, r_n, r_cs;
    bit ok;
    logic [1:0] m;
    logic [31:0] r_w, r_sw;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst:busy", 64'(busy), 64'(0));
    check("rst:ack", 64'(ack), 64'(0));
    check("rst:rd_data", 64'(rd_data), 64'(0));
    check("rst:cs_n", 64'(cs_n), 64'(4'hF));
    check("rst:sclk_mosi", 64'({sclk, mosi}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, div 1, 8 bits, loopback
    do_xfer("m0_a5", 32'hA5, 8, 1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1);

    // Mode 3, LSB first, 12 bits, cs 2, slave returns 0xABC
    m = MODE3;
    do_xfer("m3_lsb", 32'h5C3, 12, 2, m[1], m[0], 1'b1, 2, 32'hABC, 1'b0);

    // nbits=0 means full width, div 0
    do_xfer("full32", 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 1'b0, 1, 32'h0, 1'b1);

    // Single-bit transfers in modes 1 and 2 with miso held high
    m = MODE1;
    do_xfer("m1_1b", 32'h0, 1, 1, m[1], m[0], 1'b0, 3, 32'hFFFF_FFFF, 1'b0);
    m = MODE2;
    do_xfer("m2_1b", 32'h1, 1, 2, m[1], m[0], 1'b1, 0, 32'hFFFF_FFFF, 1'b0);

    // req held through a transfer: next accept lands in the ack cycle
    set_cfg(32'hA5, 8, 1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
    snap_acks = acks; snap_edges = sclk_edges;
    req = 1'b1;
    @(negedge clk);
    acc1 = cyc;
    wr_data = 32'h11;
    wait_ack(60, a1, ok);
    check("held:ack1_seen", 64'(ok), 64'(1));
    check("held:lat1", 64'(a1 - acc1), 64'(36));
    check("held:rd1", 64'(rd_data), 64'(32'hA5));
    @(negedge clk);
    acc2 = cyc;
    req = 1'b0;
    check("held:busy2", 64'(busy), 64'(1));
    check("held:acc2_at_ack", 64'(acc2 - a1), 64'(1));
    wait_ack(60, a2, ok);
    check("held:ack2_seen", 64'(ok), 64'(1));
    check("held:lat2", 64'(a2 - acc2), 64'(36));
    check("held:rd2", 64'(rd_data), 64'(32'h11));
    repeat (20) @(negedge clk);
    check("held:acks", 64'(acks - snap_acks), 64'(2));
    check("held:edges", 64'(sclk_edges - snap_edges), 64'(32));

    // Reset during half-period 5 of an 8-bit transfer
    set_cfg(32'h3C, 8, 1, 1'b0, 1'b0, 1'b0, 1, 32'h0, 1'b1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (12) @(negedge clk);
    check("mid:sclk_high", 64'(sclk), 64'(1));
    snap_acks = acks;
    rst_n = 1'b0;
    #1;
    check("mid_rst:outs", 64'({busy, ack, sclk, cs_n}), 64'({1'b0, 1'b0, 1'b0, 4'hF}));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst:no_ack", 64'(acks - snap_acks), 64'(0));
    do_xfer("post_rst", 32'h96, 8, 1, 1'b0, 1'b0, 1'b0, 1, 32'h0, 1'b1);

    // Randomised transfers against the reference model
    for (int t = 0; t < 8; t++) begin
      r_w  = $urandom;
      r_sw = $urandom;
      r_n  = int'($urandom_range(0, 40));
      r_d  = int'($urandom_range(0, 3));
      r_cs = int'($urandom_range(0, 3));
      m    = 2'($urandom_range(0, 3));
      do_xfer($sformatf("rnd%0d", t), r_w, r_n, r_d, m[1], m[0], 1'($urandom_range(0, 1)),
              r_cs, r_sw, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised full-duplex SPI master, next generation of the team's single-channel SPI master. Runtime-selectable CPOL/CPHA mode, clock divider, transfer length and bit order, multiple chip selects, and a clean req/ack handshake. Sits between register/sequencer logic and off-chip SPI devices such as ADCs, DACs and PLLs.

Parameters:
DATA_W, 32, maximum bits per transfer; width of wr_data and rd_data.
NCS, 4, number of chip-select outputs.
DIV_W, 16, width of the clock-divider input.
MOSI_IDLE, 0, mosi level when no transfer is active.

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  asynchronous, active-low reset.
req  in  1  transfer request; accepted only while busy=0.
wr_data  in  DATA_W  data to shift out; latched on accept.
nbits  in  clog2(DATA_W+1)  bits to transfer; 0 or >DATA_W means DATA_W; latched on accept.
div  in  DIV_W  SCLK half-period = div+1 clk cycles; latched on accept.
cpol  in  1  SCLK idle level; latched on accept.
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
lsb_first  in  1  1 = LSB shifted first; latched on accept.
cs_sel  in  clog2(NCS)  chip select to assert; latched on accept.
busy  out  1  high from the cycle after accept until the cycle ack is asserted.
ack  out  1  one-cycle pulse at transfer end.
rd_data  out  DATA_W  received word; valid from ack until the next ack.
sclk  out  1  SPI clock.
mosi  out  1  master out, slave in.
miso  in  1  master in, slave out; synchronous to sclk.
cs_n  out  NCS  active-low chip selects.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, ack=0, rd_data=0, sclk=0, mosi=MOSI_IDLE, cs_n all 1, all counters 0. Reset mid-transfer aborts immediately and produces no ack.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - sclk follows the registered cpol input.
  - On a cycle with req=1 and busy=0, latch the configuration and go to SETUP at the next edge. busy and cs_n[cs_sel] go active on that edge.
  - If cs_sel>=NCS, the transfer runs with no chip select asserted.
- SETUP: lasts div+1 cycles. sclk=cpol. If cpha=0, mosi presents the first bit at SETUP entry.
- SHIFT:
  - Lasts 2*N half-periods, where N is the effective nbits. Each half-period is div+1 cycles.
  - sclk toggles at the start of every half-period after the first one.
  - The leading edge is at the end of an even half-period and the trailing edge at the end of an odd one.
  - cpha=0: sample miso on the leading edge; change mosi on the trailing edge (not after the last bit).
  - cpha=1: change mosi on the leading edge (first bit at the first leading edge); sample on the trailing edge.
  - Sampling uses the clk edge at which sclk transitions.
- HOLD: lasts div+1 cycles. sclk=cpol, mosi holds the last bit.
- End of HOLD, next edge:
  - cs_n all high, busy=0, ack=1 for one cycle, rd_data updated, mosi=MOSI_IDLE, return to IDLE.
  - A new req is accepted in the ack cycle itself.
- Latency: from the accept edge to the ack edge is (div+1)*(2N+2) cycles.
- Bit order:
  - MSB-first: transmit wr_data[N-1] down to wr_data[0]; rd_data is right-justified, first received bit at rd_data[N-1].
  - LSB-first: transmit wr_data[0] upward; first received bit at rd_data[0].
  - In both orders, rd_data[DATA_W-1:N] = 0.
- A req while busy=1 is ignored, not queued. Changes to configuration inputs during a transfer have no effect.
- div=0 gives SCLK = clk/2. Counters are DIV_W wide and never wrap within a half-period.

Decomposition:
- Package spi_master_gen_pkg: state enum (IDLE/SETUP/SHIFT/HOLD), the clog2-derived width constants, and the mode encoding constants (MODE0..MODE3 as {cpol,cpha}).
- One sub-module, spi_clk_gen: the half-period counter. It takes div and an enable, and produces half-period-end strobes plus a leading/trailing phase flag.
- Shift registers and the FSM stay in the top level.

Test Plan:
- Mode 0, div=1, nbits=8, wr_data=0xA5, miso looped to mosi -> 8 sclk pulses idle-low, rd_data=0x000000A5, ack exactly 36 cycles after accept, cs_n[0] low throughout.
- Mode 3, lsb_first=1, nbits=12, wr_data=0x5C3, cs_sel=2, slave model returns 0xABC LSB-first -> mosi order 1,1,0,0,0,0,1,1,1,0,1,0; rd_data=0xABC; sclk idles high; only cs_n[2] toggles.
- nbits=0, div=0, wr_data=0xDEADBEEF, loopback -> 32 bits transferred, rd_data=0xDEADBEEF, ack 66 cycles after accept.
- req held high through a transfer with new wr_data=0x11 -> second transfer starts only at the ack cycle; exactly 2 acks; no extra sclk edges.
- rst_n pulled low at half-period 5 of an 8-bit transfer -> cs_n all 1, sclk=0, busy=0 immediately; no ack; the next req completes normally.
- Modes 1 and 2, nbits=1, miso held 1 -> rd_data=0x1; a single sclk pulse with polarity and sampling edge as specified.
